// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between the table loader (writes)
// and the two DDS lookup read ports (sin = port 0, cos = port 1).
// All SRAM controls and acks are registered one cycle after the decision.
// A LOAD/RUN sequencer holds reads off until the table load completes.
// Read returns are tracked with an RD_LAT-deep tag pipeline.
module sram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_ack,
    output logic              rd0_valid,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_ack,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    output logic              running,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD0,
        GNT_RD1
    } grant_e;

    state_e              state_q;
    logic                running_q;

    logic                wr_ack_q;
    logic                rd0_ack_q;
    logic                rd1_ack_q;
    logic                rr_ptr_q;      // 0: rd0 preferred, 1: rd1 preferred
    logic                sram_wen_q;
    logic [ADDR_W-1:0]   sram_addr_q;
    logic [DATA_W-1:0]   sram_wdata_q;

    logic [RD_LAT-1:0]   tag_vld_q;
    logic [RD_LAT-1:0]   tag_port_q;
    logic                rd0_valid_q;
    logic                rd1_valid_q;
    logic [DATA_W-1:0]   rd0_data_q;
    logic [DATA_W-1:0]   rd1_data_q;

    logic                wr_elig;
    logic                rd0_elig;
    logic                rd1_elig;
    grant_e              grant_d;

    // Decide this cycle's grant from the live requests, masking any requester
    // whose ack is already high so a held request is not granted twice.
    // The write mask also forces the cycle after a write grant to serve a
    // pending read, which is what keeps the DDS from starving during rewrites.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_d  = GNT_NONE;
        wr_elig  = wr_req && !wr_ack_q;
        rd0_elig = (state_q == ST_RUN) && rd0_req && !rd0_ack_q;
        rd1_elig = (state_q == ST_RUN) && rd1_req && !rd1_ack_q;

        if (wr_elig) begin
            grant_d = GNT_WR;
        end else if (rd0_elig && rd1_elig) begin
            grant_d = rr_ptr_q ? GNT_RD1 : GNT_RD0;
        end else if (rd0_elig) begin
            grant_d = GNT_RD0;
        end else if (rd1_elig) begin
            grant_d = GNT_RD1;
        end
    end

    // LOAD/RUN sequencer; running is registered together with the state.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values of the others.
        if (rst) begin
            state_q   <= ST_LOAD;
            running_q <= 1'b0;
        end else if (state_q == ST_LOAD && load_done) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
        end
    end

    // Register the grant onto the SRAM port and the matching ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack_q     <= 1'b0;
            rd0_ack_q    <= 1'b0;
            rd1_ack_q    <= 1'b0;
            rr_ptr_q     <= 1'b0;
            sram_wen_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            wr_ack_q   <= (grant_d == GNT_WR);
            rd0_ack_q  <= (grant_d == GNT_RD0);
            rd1_ack_q  <= (grant_d == GNT_RD1);
            sram_wen_q <= (grant_d == GNT_WR);
            case (grant_d)
                GNT_WR: begin
                    sram_addr_q  <= wr_addr;
                    sram_wdata_q <= wr_data;
                end
                GNT_RD0: begin
                    sram_addr_q <= rd0_addr;
                    rr_ptr_q    <= 1'b1;
                end
                GNT_RD1: begin
                    sram_addr_q <= rd1_addr;
                    rr_ptr_q    <= 1'b0;
                end
                default: begin
                    // Idle: address and write data hold their last values.
                end
            endcase
        end
    end

    // Carry each read's port id alongside the SRAM latency and capture the
    // returning word into that port's data register when the tag exits.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag pipeline is reset because a stale valid bit would produce a spurious return; the data registers are reset only because their reset value is visible at the ports.
            tag_vld_q   <= '0;
            tag_port_q  <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
            rd0_data_q  <= '0;
            rd1_data_q  <= '0;
        end else begin
            tag_vld_q[0]  <= (grant_d == GNT_RD0) || (grant_d == GNT_RD1);
            tag_port_q[0] <= (grant_d == GNT_RD1);
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_port_q[i] <= tag_port_q[i-1];
            end

            rd0_valid_q <= tag_vld_q[RD_LAT-1] && !tag_port_q[RD_LAT-1];
            rd1_valid_q <= tag_vld_q[RD_LAT-1] &&  tag_port_q[RD_LAT-1];
            if (tag_vld_q[RD_LAT-1] && !tag_port_q[RD_LAT-1]) begin
                rd0_data_q <= sram_rdata;
            end
            if (tag_vld_q[RD_LAT-1] && tag_port_q[RD_LAT-1]) begin
                rd1_data_q <= sram_rdata;
            end
        end
    end

    assign running    = running_q;
    assign wr_ack     = wr_ack_q;
    assign rd0_ack    = rd0_ack_q;
    assign rd1_ack    = rd1_ack_q;
    assign sram_wen   = sram_wen_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign rd0_valid  = rd0_valid_q;
    assign rd1_valid  = rd1_valid_q;
    assign rd0_data   = rd0_data_q;
    assign rd1_data   = rd1_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: drives two arbiter instances (read latency 1 and 3) with
// the same request stream; each has its own SRAM model and its own
// transaction-level reference model that is compared on every cycle.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_done = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd0_req = 1'b0;
    logic        rd1_req = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd0_addr = '0;
    logic [15:0] rd1_addr = '0;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    bit live   = 1'b0;

    typedef struct {
        int          due;
        int          port;
        logic [15:0] data;
    } ret_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        wr_ack, rd0_ack, rd1_ack, rd0_valid, rd1_valid, running, sram_wen;
        logic [15:0] rd0_data, rd1_data, sram_addr, sram_wdata, sram_rdata;

        sram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .load_done (load_done),
            .wr_req    (wr_req),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .wr_ack    (wr_ack),
            .rd0_req   (rd0_req),
            .rd0_addr  (rd0_addr),
            .rd0_ack   (rd0_ack),
            .rd0_valid (rd0_valid),
            .rd0_data  (rd0_data),
            .rd1_req   (rd1_req),
            .rd1_addr  (rd1_addr),
            .rd1_ack   (rd1_ack),
            .rd1_valid (rd1_valid),
            .rd1_data  (rd1_data),
            .running   (running),
            .sram_wen  (sram_wen),
            .sram_addr (sram_addr),
            .sram_wdata(sram_wdata),
            .sram_rdata(sram_rdata)
        );

        // SRAM: 64 words (low address bits), reads the registered address and
        // delivers the word LAT cycles after the address appeared.
        logic [15:0] mem_s [64];
        logic [15:0] dly [3];
        initial begin
            for (int i = 0; i < 64; i++) mem_s[i] = init_word(i);
            for (int i = 0; i < 3; i++) dly[i] = '0;
        end
        always @(posedge clk) begin
            if (sram_wen) mem_s[sram_addr[5:0]] <= sram_wdata;
            dly[0] <= mem_s[sram_addr[5:0]];
            dly[1] <= dly[0];
            dly[2] <= dly[1];
        end
        assign sram_rdata = (LAT == 1) ? mem_s[sram_addr[5:0]] : dly[LAT-2];

        // Reference model: which requester is served each cycle, plus a queue
        // of promised read returns (due cycle, port, word).
        int          m_prev = -1;   // grant visible as an ack this cycle: 0 wr, 1 rd0, 2 rd1
        bit          m_run = 1'b0;
        int          m_pref = 0;    // port preferred when both reads compete
        bit          m_wen = 1'b0;
        logic [15:0] m_addr = '0, m_wdata = '0, m_d0 = '0, m_d1 = '0;
        bit          m_v0 = 1'b0, m_v1 = 1'b0;
        int          m_cyc = 0;
        ret_t        m_q[$];
        logic [15:0] mem_m [64];
        initial for (int i = 0; i < 64; i++) mem_m[i] = init_word(i);

        always @(posedge clk) begin
            int   gnt;
            bit   can_w, can0, can1;
            ret_t r;
            m_cyc++;
            if (rst) begin
                m_prev = -1; m_run = 1'b0; m_pref = 0; m_wen = 1'b0;
                m_addr = '0; m_wdata = '0; m_d0 = '0; m_d1 = '0;
                m_v0 = 1'b0; m_v1 = 1'b0;
                m_q.delete();
            end else begin
                can_w = wr_req && (m_prev != 0);
                can0  = m_run && rd0_req && (m_prev != 1);
                can1  = m_run && rd1_req && (m_prev != 2);
                if (m_prev == 0 && (can0 || can1)) can_w = 1'b0;
                if (can_w) gnt = 0;
                else if (can0 && can1) gnt = (m_pref == 0) ? 1 : 2;
                else if (can0) gnt = 1;
                else if (can1) gnt = 2;
                else gnt = -1;

                m_v0 = 1'b0;
                m_v1 = 1'b0;
                if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
                    r = m_q.pop_front();
                    if (r.port == 0) begin m_v0 = 1'b1; m_d0 = r.data; end
                    else             begin m_v1 = 1'b1; m_d1 = r.data; end
                end

                m_wen = (gnt == 0);
                if (gnt == 0) begin
                    m_addr = wr_addr; m_wdata = wr_data;
                    mem_m[wr_addr[5:0]] = wr_data;
                end else if (gnt == 1) begin
                    m_addr = rd0_addr; m_pref = 1;
                    m_q.push_back('{due: m_cyc + LAT, port: 0, data: mem_m[rd0_addr[5:0]]});
                end else if (gnt == 2) begin
                    m_addr = rd1_addr; m_pref = 0;
                    m_q.push_back('{due: m_cyc + LAT, port: 1, data: mem_m[rd1_addr[5:0]]});
                end
                if (!m_run && load_done) m_run = 1'b1;
                m_prev = gnt;
            end
        end

        always @(negedge clk) begin
            if (live) begin
                check($sformatf("lat%0d_acks", LAT), {wr_ack, rd0_ack, rd1_ack},
                      {m_prev == 0, m_prev == 1, m_prev == 2});
                check($sformatf("lat%0d_sram", LAT), {sram_wen, sram_addr, sram_wdata},
                      {m_wen, m_addr, m_wdata});
                check($sformatf("lat%0d_running", LAT), running, m_run);
                check($sformatf("lat%0d_rd0", LAT), {rd0_valid, rd0_data}, {m_v0, m_d0});
                check($sformatf("lat%0d_rd1", LAT), {rd1_valid, rd1_data}, {m_v1, m_d1});
            end
        end
    end

    task automatic idle(input int n);
        wr_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n_ack, n_bad, n_both, n_idle, n_w, n_r, last, k;
        int ack_t0, val_t0, ack_t1, val_t1;

        repeat (3) @(negedge clk);
        live = 1'b1;
        check("reset_outputs",
              {lane[0].sram_wen, lane[0].sram_addr, lane[0].sram_wdata, lane[0].running,
               lane[0].wr_ack, lane[0].rd0_ack, lane[0].rd1_ack, lane[0].rd0_valid,
               lane[0].rd1_valid, lane[0].rd0_data, lane[0].rd1_data}, '0);

        // Reads in LOAD are never served.
        rst = 1'b0;
        rd0_req = 1'b1; rd0_addr = 16'h0010;
        n_ack = 0; n_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (lane[0].rd0_ack || lane[1].rd0_ack) n_ack++;
            if (lane[0].sram_wen || lane[0].running) n_bad++;
        end
        check("load_rd0_acks", n_ack, 0);
        check("load_wen_or_running", n_bad, 0);

        // Loader write during LOAD, then load_done.
        wr_req = 1'b1; wr_addr = 16'h0005; wr_data = 16'hBEEF;
        k = 0;
        do begin @(negedge clk); k++; end while (!lane[0].wr_ack && k < 8);
        check("load_wr_ack_seen", lane[0].wr_ack, 1'b1);
        check("load_wr_latency", k, 1);
        check("load_wr_sram", {lane[0].sram_wen, lane[0].sram_addr, lane[0].sram_wdata},
              {1'b1, 16'h0005, 16'hBEEF});
        wr_req = 1'b0;
        @(negedge clk);
        check("load_wen_single", {lane[0].sram_wen, lane[0].wr_ack}, 2'b00);
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        check("load_to_run", lane[0].running, 1'b1);
        idle(6);

        // Both reads held: strict alternation, one access per cycle.
        rd0_req = 1'b1; rd1_req = 1'b1;
        rd0_addr = 16'h0005; rd1_addr = 16'h1003;
        n_bad = 0; n_both = 0; n_idle = 0; last = -1;
        ack_t0 = -1; val_t0 = -1; ack_t1 = -1; val_t1 = -1;
        repeat (14) begin
            @(negedge clk);
            if (lane[0].rd0_ack && lane[0].rd1_ack) n_both++;
            if (!lane[0].rd0_ack && !lane[0].rd1_ack) n_idle++;
            if ((lane[0].rd0_ack && last == 0) || (lane[0].rd1_ack && last == 1)) n_bad++;
            last = lane[0].rd0_ack ? 0 : (lane[0].rd1_ack ? 1 : -1);
            if (lane[0].rd0_ack && ack_t0 < 0) ack_t0 = cyc_n;
            if (lane[0].rd0_valid && ack_t0 >= 0 && val_t0 < 0) val_t0 = cyc_n;
            if (lane[1].rd0_ack && ack_t1 < 0) ack_t1 = cyc_n;
            if (lane[1].rd0_valid && ack_t1 >= 0 && val_t1 < 0) val_t1 = cyc_n;
            if (lane[0].rd0_ack) rd0_addr = 16'($urandom);
            if (lane[0].rd1_ack) rd1_addr = 16'($urandom);
        end
        check("rr_two_acks", n_both, 0);
        check("rr_idle_cycles", n_idle, 0);
        check("rr_not_alternating", n_bad, 0);
        check("rd_latency_1", val_t0 - ack_t0, 1);
        check("rd_latency_3", val_t1 - ack_t1, 3);
        idle(6);

        // Write and read both held: write, read, write, read ...
        wr_req = 1'b1; rd0_req = 1'b1;
        wr_addr = 16'h0021; wr_data = 16'h1234; rd0_addr = 16'h0021;
        n_w = 0; n_r = 0; n_bad = 0; last = -1;
        repeat (10) begin
            @(negedge clk);
            if (lane[0].wr_ack) n_w++;
            if (lane[0].rd0_ack) n_r++;
            if ((lane[0].wr_ack && last == 0) || (lane[0].rd0_ack && last == 1) ||
                (!lane[0].wr_ack && !lane[0].rd0_ack)) n_bad++;
            last = lane[0].wr_ack ? 0 : (lane[0].rd0_ack ? 1 : -1);
            if (lane[0].wr_ack) begin wr_addr = 16'($urandom); wr_data = 16'($urandom); end
            if (lane[0].rd0_ack) rd0_addr = 16'($urandom);
        end
        check("wr_rd_writes", n_w, 5);
        check("wr_rd_reads", n_r, 5);
        check("wr_rd_order", n_bad, 0);
        idle(6);

        // Reset with two reads in flight on the latency-3 lane.
        rd0_req = 1'b1; rd1_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("inflight_acks", {lane[1].rd0_ack || lane[1].rd1_ack}, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs",
              {lane[1].sram_wen, lane[1].sram_addr, lane[1].sram_wdata, lane[1].running,
               lane[1].wr_ack, lane[1].rd0_ack, lane[1].rd1_ack, lane[1].rd0_valid,
               lane[1].rd1_valid, lane[1].rd0_data, lane[1].rd1_data}, '0);
        n_bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (lane[0].rd0_valid || lane[0].rd1_valid || lane[1].rd0_valid || lane[1].rd1_valid ||
                lane[0].rd0_ack || lane[0].rd1_ack || lane[1].running) n_bad++;
        end
        check("midrst_no_returns", n_bad, 0);

        // Randomized traffic with occasional load_done and reset.
        idle(1);
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            load_done = ($urandom_range(0, 19) == 0);
            if (lane[0].wr_ack || !wr_req) begin
                wr_req  = ($urandom_range(0, 2) == 0);
                wr_addr = 16'($urandom);
                wr_data = 16'($urandom);
            end
            if (lane[0].rd0_ack || !rd0_req) begin
                rd0_req  = ($urandom_range(0, 2) != 0);
                rd0_addr = 16'($urandom);
            end
            if (lane[0].rd1_ack || !rd1_req) begin
                rd1_req  = ($urandom_range(0, 2) != 0);
                rd1_addr = 16'($urandom);
            end
        end
        rst = 1'b0; load_done = 1'b0;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single-port sram16x16 lookup memory between the flash-to-SRAM loader (write requester) and the two DDS table-lookup read ports (sin and cos paths). It replaces the hard busy-based address/write-enable mux with a registered request/acknowledge arbiter. It adds a LOAD/RUN sequencing FSM, so reads are held off until the table load completes. It also supports runtime table rewrites without starving the DDS.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 16, SRAM data width
RD_LAT, 1, SRAM read latency in clk cycles (address registered at SRAM to data valid), legal 1..3

Ports:
clk  in  1  system clock (PLL clock domain)
rst  in  1  reset, synchronous, active-high
load_done  in  1  single-cycle pulse from loader: table load complete
wr_req  in  1  write request, held until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  1-cycle pulse: write issued to SRAM this cycle
rd0_req  in  1  read request port 0 (sin), held until rd0_ack
rd0_addr  in  ADDR_W  read address port 0
rd0_ack  out  1  1-cycle pulse: port 0 read issued this cycle
rd0_valid  out  1  1-cycle pulse: rd0_data updated
rd0_data  out  DATA_W  port 0 read data, held between valids
rd1_req, rd1_addr, rd1_ack, rd1_valid, rd1_data: same as port 0 (cos)
running  out  1  high in RUN state
sram_wen  out  1  SRAM write enable (registered)
sram_addr  out  ADDR_W  SRAM address (registered)
sram_wdata  out  DATA_W  SRAM write data (registered)
sram_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset: sram_wen=0, sram_addr=0, sram_wdata=0, all acks/valids=0, rd0_data=rd1_data=0, running=0, round-robin pointer=rd0, state=LOAD, read-tag pipeline cleared.
- FSM LOAD: only wr_req can be granted; read requests stay pending (no ack). load_done -> RUN on the next cycle. A load_done coinciding with a write grant still performs the write.
- FSM RUN: running=1. load_done is ignored. Only rst returns the FSM to LOAD.
- Arbitration: a decision is made in cycle t from the current reqs. SRAM outputs and the matching ack are registered and appear in cycle t+1. At most one access is issued per cycle.
- A requester whose ack is high in the current cycle is masked from that cycle's decision, so a held req is never double-granted. Per-port maximum rate is 1 access / 2 cycles. Alternating rd0/rd1 gives 1 access/cycle.
- RUN priority: write first, then reads round-robin. The pointer toggles to the other port after each read grant.
- Anti-starvation: after a write grant, if any unmasked read is pending, the next grant must go to a read.
- Idle cycle (no grant): sram_wen=0; sram_addr and sram_wdata hold their previous values.
- Write grant: sram_wen=1 for exactly one cycle with wr_addr/wr_data latched from cycle t.
- Read grant: sram_wen=0 and sram_addr=rdN_addr. A tag (port id, valid) enters an RD_LAT-deep shift pipeline.
- Read return: when a tag exits the pipeline (RD_LAT cycles after rdN_ack), capture sram_rdata into rdN_data and pulse rdN_valid. Reads return strictly in issue order.
- Reset mid-operation:
  - In-flight tags are discarded; no valid pulses occur after rst.
  - Pending reqs are not acked until re-arbitrated.
  - The FSM restarts in LOAD.
- Address and data widths are passed through unmodified; no arithmetic on addresses.

Test Plan:
1. rst then rd0_req=1 addr=0x0010 in LOAD, no load_done for 20 cycles -> rd0_ack never asserts, sram_wen=0, running=0.
2. LOAD: wr_req held with addr 0x0005 data 0xBEEF -> wr_ack pulses once, sram_wen=1 for one cycle with addr 0x0005/data 0xBEEF. Then pulse load_done -> running=1 next cycle.
3. RUN: rd0_req and rd1_req both held continuously (RD_LAT=1, SRAM model) -> grants alternate rd0,rd1,rd0,...; each rdN_valid arrives 1 cycle after its ack with the correct word; no cycle has two acks.
4. RUN: wr_req and rd0_req both held -> order is write, read, write, read. The read is never delayed more than 1 cycle behind a write grant.
5. RD_LAT=3: back-to-back alternating reads -> each rdN_valid occurs exactly 3 cycles after the matching rdN_ack, in order, with data from the addressed word.
6. Assert rst for 1 cycle while 2 reads are in flight -> no rd0_valid/rd1_valid afterwards, all outputs at reset values, state LOAD.
